raster_scan: RTL
================

Name: raster_scan

Overview:
Upstream feeder for the barycentric stage. It accepts one screen-space triangle, computes its screen-clamped bounding box, then emits every pixel in that box in row-major order, one per cycle. Each emitted pixel carries the triangle vertices, so the barycentric stage receives a point plus vertices on every valid beat. A valid/ready handshake on both sides allows stalls from the triangle source and from downstream.

Parameters:
H_RES, 320, screen width in pixels; legal x is 0..H_RES-1.
V_RES, 240, screen height in pixels; legal y is 0..V_RES-1.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-high
valid_in  input  1  triangle on vertices_in is valid
ready_out  output  1  block can accept a triangle (high only in IDLE)
vertices_in  input  [2:0][1:0][16:0]  three vertices; [v][0]=x, [v][1]=y; signed two's complement, integer pixel units
ready_in  input  1  downstream accepts the current beat
valid_out  output  1  point_out/vertices_out valid
point_out  output  [1:0][16:0]  pixel coordinate; [0]=x, [1]=y; always non-negative and on-screen
vertices_out  output  [2:0][1:0][16:0]  registered copy of the accepted triangle
last_out  output  1  asserted with the final pixel of the triangle
busy_out  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE, valid_out=0, last_out=0, busy_out=0, ready_out=1.
  - point_out and vertices_out are cleared to 0.
- States: IDLE, SETUP, SCAN.
- IDLE:
  - ready_out=1.
  - When valid_in && ready_out: register vertices_in, go to SETUP.
- SETUP (exactly 1 cycle):
  - Compute signed xmin/xmax/ymin/ymax over the three vertices.
  - Empty case: if xmax<0, ymax<0, xmin>H_RES-1 or ymin>V_RES-1, return to IDLE with no output beats.
  - Otherwise clamp each bound to [0,H_RES-1] or [0,V_RES-1], load the cursor to (xmin_c,ymin_c), go to SCAN.
- SCAN:
  - valid_out=1 and point_out=cursor.
  - A beat completes on valid_out && ready_in.
  - On completion: if x<xmax_c, x++; else x=xmin_c and y++.
  - The completing beat at (xmax_c,ymax_c) has last_out=1; next state is IDLE, with valid_out low the following cycle.
- Stall: while valid_out && !ready_in, point_out, vertices_out, last_out and valid_out hold stable.
- Latency:
  - Triangle accepted at edge N; first valid_out at edge N+2.
  - With ready_in held high: one pixel per cycle, (xmax_c-xmin_c+1)*(ymax_c-ymin_c+1) beats.
  - Next triangle is accepted no earlier than the cycle after last completes (ready_out rises with IDLE).
- Degenerate cases:
  - Single-pixel box gives one beat with last_out=1.
  - Collinear and zero-area triangles are still scanned; rejecting them is downstream's job.
- Arithmetic:
  - All comparisons are signed 17-bit; cursor counters are 17-bit.
  - No wrap is possible, since clamped bounds are within the resolution.
- Reset mid-SETUP or mid-SCAN: immediate return to IDLE, valid_out=0, partial triangle discarded.
- valid_in outside IDLE is ignored; no back-to-back pipelining of triangles is required.

Decomposition:
- Shared graphics package gfx_pkg holds:
  - coord_t (logic signed [16:0]) and vertex_t ([1:0] coord_t);
  - the default H_RES/V_RES constants;
  - the state enum for this block.
- One sub-module, min_max3: combinational signed min and max of three coord_t values. It is instantiated twice, for x and y, in SETUP.

Test Plan:
- Basic scan: triangle (0,0),(2,0),(0,1), ready_in=1 -> 6 beats (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); first beat 2 cycles after accept; last_out only on (2,1).
- Backpressure: same triangle, ready_in low on alternate cycles -> same 6 points in order, none duplicated or lost; outputs stable during every stall cycle.
- Clamping: triangle (-5,-3),(1,-3),(-5,1) -> box x 0..1, y 0..1, 4 beats (0,0),(1,0),(0,1),(1,1).
- Off-screen: triangle (400,10),(410,10),(400,20) with H_RES=320 -> zero beats, ready_out high again 2 cycles after accept.
- Single pixel: all vertices (7,9) -> one beat (7,9) with last_out=1; vertices_out all equal (7,9).
- Reset mid-scan: assert rst_in during the 3rd beat of the basic scan -> valid_out=0 immediately, ready_out=1; a new triangle (5,5),(5,5),(5,5) then yields exactly beat (5,5).

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics types: signed screen coordinates, default resolution, and
// the raster scanner state encoding.
package gfx_pkg;

  typedef logic signed [16:0] coord_t;
  typedef coord_t [1:0] vertex_t;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/min_max3.sv
// Combinational signed minimum and maximum of three coordinates.
module min_max3
  import gfx_pkg::*;
(
  input  coord_t i_a,
  input  coord_t i_b,
  input  coord_t i_c,
  output coord_t o_min,
  output coord_t o_max
);

  coord_t w_min_ab;
  coord_t w_max_ab;

  assign w_min_ab = (i_a < i_b) ? i_a : i_b;
  assign w_max_ab = (i_a > i_b) ? i_a : i_b;
  assign o_min    = (w_min_ab < i_c) ? w_min_ab : i_c;
  assign o_max    = (w_max_ab > i_c) ? w_max_ab : i_c;

endmodule

// File: rtl/raster_scan.sv
// Accepts one triangle, clamps its bounding box to the screen and emits every
// pixel of the box in row-major order alongside the triangle vertices.
module raster_scan
  import gfx_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [2:0][1:0][16:0]  vertices_in,
  input  logic                   ready_in,
  output logic                   valid_out,
  output logic [1:0][16:0]       point_out,
  output logic [2:0][1:0][16:0]  vertices_out,
  output logic                   last_out,
  output logic                   busy_out
);

  localparam coord_t X_LIM = coord_t'(H_RES - 1);
  localparam coord_t Y_LIM = coord_t'(V_RES - 1);
  localparam coord_t ZERO  = coord_t'(0);
  localparam coord_t ONE   = coord_t'(1);

  scan_state_e r_state;
  scan_state_e w_state_nxt;

  logic [2:0][1:0][16:0] r_vert;
  coord_t r_x;
  coord_t r_y;
  coord_t r_xmin_c;
  coord_t r_xmax_c;
  coord_t r_ymax_c;

  coord_t w_xmin;
  coord_t w_xmax;
  coord_t w_ymin;
  coord_t w_ymax;
  logic   w_empty;
  logic   w_fire;
  logic   w_at_end;

  function automatic coord_t clamp(input coord_t v, input coord_t hi);
    if (v < ZERO)
      return ZERO;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

  min_max3 u_mm_x (
    .i_a   (coord_t'(r_vert[0][0])),
    .i_b   (coord_t'(r_vert[1][0])),
    .i_c   (coord_t'(r_vert[2][0])),
    .o_min (w_xmin),
    .o_max (w_xmax)
  );

  min_max3 u_mm_y (
    .i_a   (coord_t'(r_vert[0][1])),
    .i_b   (coord_t'(r_vert[1][1])),
    .i_c   (coord_t'(r_vert[2][1])),
    .o_min (w_ymin),
    .o_max (w_ymax)
  );

  // A box lying entirely off one screen edge produces no beats at all.
  assign w_empty  = (w_xmax < ZERO) || (w_ymax < ZERO) ||
                    (w_xmin > X_LIM) || (w_ymin > Y_LIM);
  assign w_at_end = (r_x == r_xmax_c) && (r_y == r_ymax_c);
  assign w_fire   = valid_out && ready_in;

  always_comb begin
    w_state_nxt = r_state;
    ready_out   = 1'b0;
    valid_out   = 1'b0;
    busy_out    = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        ready_out = 1'b1;
        busy_out  = 1'b0;
        if (valid_in)
          w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = w_empty ? ST_IDLE : ST_SCAN;
      end
      ST_SCAN: begin
        valid_out = 1'b1;
        if (ready_in && w_at_end)
          w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_vert   <= '0;
      r_x      <= ZERO;
      r_y      <= ZERO;
      r_xmin_c <= ZERO;
      r_xmax_c <= ZERO;
      r_ymax_c <= ZERO;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (valid_in)
            r_vert <= vertices_in;
        end
        ST_SETUP: begin
          r_xmin_c <= clamp(w_xmin, X_LIM);
          r_xmax_c <= clamp(w_xmax, X_LIM);
          r_ymax_c <= clamp(w_ymax, Y_LIM);
          r_x      <= clamp(w_xmin, X_LIM);
          r_y      <= clamp(w_ymin, Y_LIM);
        end
        ST_SCAN: begin
          // The cursor is left on the final pixel once the box is finished.
          if (w_fire && !w_at_end) begin
            if (r_x < r_xmax_c) begin
              r_x <= r_x + ONE;
            end else begin
              r_x <= r_xmin_c;
              r_y <= r_y + ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign point_out[0]  = r_x;
  assign point_out[1]  = r_y;
  assign vertices_out  = r_vert;
  assign last_out      = valid_out && w_at_end;

endmodule
